bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 10, meaning the BRAM address width.
REQ-002 The module SHALL have parameter DATA_W, default 8, meaning the BRAM data width.
REQ-003 The module SHALL have parameter RD_LAT, default 1, legal values 1..2, meaning the BRAM read latency in cycles from en to dout valid.
REQ-004 The port list SHALL be:
- clk  in  1  sole clock; all state on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  3  per-requester request valid.
- req_ready  out  3  per-requester grant (one-hot or zero).
- req_we  in  3  per-requester write (1) or read (0).
- req_addr  in  3*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  3*DATA_W  packed write data, same packing.
- rsp_valid  out  3  per-requester read-data valid.
- rsp_rdata  out  DATA_W  read data, shared by all requesters.
- bram_en  out  1  BRAM port A enable.
- bram_we  out  1  BRAM port A write enable.
- bram_addr  out  ADDR_W  BRAM port A address.
- bram_din  out  DATA_W  BRAM port A write data.
- bram_dout  in  DATA_W  BRAM port A read data.

Function
REQ-005 Each cycle, the block SHALL grant at most one requester with req_valid=1; req_ready SHALL be combinational from req_valid and the arbitration state.
REQ-006 A transfer SHALL occur when req_valid[i] and req_ready[i] are both 1; that cycle bram_en=1, and bram_we, bram_addr and bram_din SHALL equal requester i's req_we, address and wdata, combinationally.
REQ-007 With no req_valid bit set, bram_en, bram_we and req_ready SHALL be 0, and the arbitration state SHALL hold.
REQ-008 Round-robin mode: a 2-bit pointer p (values 0..2) SHALL select the first valid requester searching p, p+1, p+2 mod 3. After a grant to i, p SHALL become (i+1) mod 3.
REQ-009 A continuously valid requester SHALL be granted within 3 cycles in round-robin mode.
REQ-010 A requester left ungranted while valid SHALL stay pending with no penalty; the arbiter SHALL NOT lock onto any requester.
REQ-011 A read transfer by requester i SHALL assert rsp_valid[i] for exactly one cycle, exactly RD_LAT cycles later, with rsp_rdata=bram_dout in that cycle.
REQ-012 Write transfers SHALL produce no rsp_valid.
REQ-013 Read responses SHALL be tracked by an RD_LAT-deep shift pipeline of {valid, 2-bit id}. Back-to-back reads SHALL be accepted every cycle, with responses in issue order.
REQ-014 rsp_valid SHALL be one-hot or zero. rsp_rdata SHALL be 0 whenever rsp_valid=0.
REQ-015 Reads and writes are issued in grant order on one port. A read granted the cycle after a write to the same address SHALL return the written data.

Reset
REQ-016 On rst_n=0, asynchronously: p=0, response pipeline cleared, rsp_valid=0, rsp_rdata=0.
REQ-017 During reset, req_ready=0 and bram_en=0.
REQ-018 Reads in flight when reset asserts SHALL be discarded and SHALL never produce rsp_valid.
REQ-019 The first arbitration after reset release SHALL favour requester 0.

Configuration
REQ-020 Macro BRAM_ARB_FIXED_PRIO_EN defined: fixed priority 0 > 1 > 2, p not implemented, REQ-009 waived.
REQ-021 Macro BRAM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-008.

Verification
REQ-022 Single write then read: req 1 writes addr 0x055 data 0xA5, then reads addr 0x055. Required: req_ready[1]=1 on each; rsp_valid=3'b010 and rsp_rdata=0xA5 RD_LAT cycles after the read.
REQ-023 All three requesters reading continuously from p=0, round-robin: grants 0,1,2,0,1,2. Each rsp_valid bit arrives RD_LAT cycles after its grant.
REQ-024 Same stimulus with BRAM_ARB_FIXED_PRIO_EN defined: requester 0 is granted every cycle, and requesters 1 and 2 are not granted until req_valid[0] drops.
REQ-025 Reset during reads: grant reads to requesters 0 and 2 on consecutive cycles (RD_LAT=2), then pull rst_n low in the following cycle. Required: no rsp_valid after reset; p=0; the first post-reset grant goes to requester 0 when all requesters are valid.
REQ-026 Idle: req_valid=0 for 10 cycles. Required: bram_en=0, req_ready=0, rsp_valid=0 throughout; p unchanged.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Three-requester arbiter in front of a single BRAM port, with read-response routing.
// Round-robin by default; define BRAM_ARB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2.
module bram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [2:0]          req_we,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_wdata,
  output logic [2:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                bram_en,
  output logic                bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_din,
  input  logic [DATA_W-1:0]   bram_dout
);

  typedef struct packed {
    logic       v;
    logic [1:0] id;
  } rsp_t;

  logic [2:0] grant;
  logic [1:0] gid;
  rsp_t       issue;
  rsp_t       pipe [RD_LAT];
  rsp_t       tail;

`ifdef BRAM_ARB_FIXED_PRIO_EN

  always_comb begin
    grant = '0;
    if (rst_n) begin
      priority case (1'b1)
        req_valid[0]: grant = 3'b001;
        req_valid[1]: grant = 3'b010;
        req_valid[2]: grant = 3'b100;
        default:      grant = 3'b000;
      endcase
    end
  end

`else

  logic [1:0] ptr;
  logic [1:0] ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= 2'd0;
    else        ptr <= ptr_nxt;
  end

  // search order starts at ptr and wraps mod 3
  always_comb begin
    grant = '0;
    if (rst_n) begin
      case (ptr)
        2'd1: begin
          priority case (1'b1)
            req_valid[1]: grant = 3'b010;
            req_valid[2]: grant = 3'b100;
            req_valid[0]: grant = 3'b001;
            default:      grant = 3'b000;
          endcase
        end
        2'd2: begin
          priority case (1'b1)
            req_valid[2]: grant = 3'b100;
            req_valid[0]: grant = 3'b001;
            req_valid[1]: grant = 3'b010;
            default:      grant = 3'b000;
          endcase
        end
        default: begin
          priority case (1'b1)
            req_valid[0]: grant = 3'b001;
            req_valid[1]: grant = 3'b010;
            req_valid[2]: grant = 3'b100;
            default:      grant = 3'b000;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    unique case (1'b1)
      grant[0]: ptr_nxt = 2'd1;
      grant[1]: ptr_nxt = 2'd2;
      grant[2]: ptr_nxt = 2'd0;
      default:  ptr_nxt = ptr;
    endcase
  end

`endif

  assign req_ready = grant;

  always_comb begin
    gid = 2'd0;
    if (grant[1])      gid = 2'd1;
    else if (grant[2]) gid = 2'd2;
  end

  always_comb begin
    bram_en   = |grant;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant[i]) begin
        bram_we   = req_we[i];
        bram_addr = req_addr[i*ADDR_W +: ADDR_W];
        bram_din  = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    issue.v  = bram_en & ~bram_we;
    issue.id = gid;
  end

  // one slot per cycle of BRAM latency; tail lines up with valid dout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= issue;
      for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign tail = pipe[RD_LAT-1];

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (tail.v) begin
      rsp_rdata = bram_dout;
      case (tail.id)
        2'd1:    rsp_valid = 3'b010;
        2'd2:    rsp_valid = 3'b100;
        default: rsp_valid = 3'b001;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed-vector bench for bram_port_arbiter with a 2-cycle BRAM model.
// Expectations follow BRAM_ARB_FIXED_PRIO_EN when it is defined.
module tb_bram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LAT = 2;
`ifdef BRAM_ARB_FIXED_PRIO_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    req_valid;
  logic [2:0]    req_ready;
  logic [2:0]    req_we;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] d1;
  logic [DW-1:0] d2;

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         d1 <= mem[bram_addr];
    end
    d2 <= d1;
  end
  assign bram_dout = d2;

  typedef struct {
    logic [2:0]    v;
    logic [2:0]    we;
    logic [AW-1:0] base;
    logic [DW-1:0] d;
    logic [2:0]    rdy;
    logic [2:0]    rsp;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t tbl [23];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int r,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, r, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] we,
                       input logic [AW-1:0] base, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*AW +: AW]  = base + AW'(i);
      req_wdata[i*DW +: DW] = d + DW'(i);
    end
  endtask

  task automatic check_row(input int r, input vec_t t);
    int idx;
    idx = t.rdy[1] ? 1 : (t.rdy[2] ? 2 : 0);
    chk("req_ready", r, 32'(req_ready), 32'(t.rdy));
    chk("bram_en", r, 32'(bram_en), 32'(|t.rdy));
    if (|t.rdy) begin
      chk("bram_we", r, 32'(bram_we), 32'(t.we[idx]));
      chk("bram_addr", r, 32'(bram_addr), 32'(t.base + AW'(idx)));
      if (t.we[idx]) chk("bram_din", r, 32'(bram_din), 32'(t.d + DW'(idx)));
    end
    chk("rsp_valid", r, 32'(rsp_valid), 32'(t.rsp));
    chk("rsp_rdata", r, 32'(rsp_rdata), 32'(t.rd));
  endtask

  task automatic idle_check(input int r);
    chk("idle_ready", r, 32'(req_ready), 32'd0);
    chk("idle_en", r, 32'(bram_en), 32'd0);
    chk("idle_rsp", r, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < (1<<AW); k++) mem[k] = 8'(k) ^ 8'h5A;

    tbl[0]  = '{3'b010, 3'b010, 10'h054, 8'hA4, 3'b010, 3'b000, 8'h00};
    tbl[1]  = '{3'b010, 3'b000, 10'h054, 8'h00, 3'b010, 3'b000, 8'h00};
    tbl[2]  = '{3'b000, 3'b000, 10'h000, 8'h00, 3'b000, 3'b000, 8'h00};
    tbl[3]  = '{3'b000, 3'b000, 10'h000, 8'h00, 3'b000, 3'b010, 8'hA5};
    tbl[4]  = '{3'b100, 3'b000, 10'h100, 8'h00, 3'b100, 3'b000, 8'h00};
    tbl[5]  = '{3'b000, 3'b000, 10'h000, 8'h00, 3'b000, 3'b000, 8'h00};
    tbl[6]  = '{3'b000, 3'b000, 10'h000, 8'h00, 3'b000, 3'b100, 8'h58};
    tbl[7]  = '{3'b111, 3'b000, 10'h200, 8'h00, 3'b001, 3'b000, 8'h00};
    tbl[8]  = '{3'b111, 3'b000, 10'h200, 8'h00,
                F ? 3'b001 : 3'b010, 3'b000, 8'h00};
    tbl[9]  = '{3'b111, 3'b000, 10'h200, 8'h00,
                F ? 3'b001 : 3'b100, 3'b001, 8'h5A};
    tbl[10] = '{3'b111, 3'b000, 10'h200, 8'h00, 3'b001,
                F ? 3'b001 : 3'b010, F ? 8'h5A : 8'h5B};
    tbl[11] = '{3'b111, 3'b000, 10'h200, 8'h00, F ? 3'b001 : 3'b010,
                F ? 3'b001 : 3'b100, F ? 8'h5A : 8'h58};
    tbl[12] = '{3'b111, 3'b000, 10'h200, 8'h00,
                F ? 3'b001 : 3'b100, 3'b001, 8'h5A};
    tbl[13] = '{3'b000, 3'b000, 10'h000, 8'h00, 3'b000,
                F ? 3'b001 : 3'b010, F ? 8'h5A : 8'h5B};
    tbl[14] = '{3'b000, 3'b000, 10'h000, 8'h00, 3'b000,
                F ? 3'b001 : 3'b100, F ? 8'h5A : 8'h58};
    tbl[15] = '{3'b110, 3'b000, 10'h300, 8'h00, 3'b010, 3'b000, 8'h00};
    tbl[16] = '{3'b110, 3'b000, 10'h300, 8'h00,
                F ? 3'b010 : 3'b100, 3'b000, 8'h00};
    tbl[17] = '{3'b000, 3'b000, 10'h000, 8'h00, 3'b000, 3'b010, 8'h5B};
    tbl[18] = '{3'b000, 3'b000, 10'h000, 8'h00, 3'b000,
                F ? 3'b010 : 3'b100, F ? 8'h5B : 8'h58};
    tbl[19] = '{3'b001, 3'b001, 10'h3F0, 8'h77, 3'b001, 3'b000, 8'h00};
    tbl[20] = '{3'b001, 3'b000, 10'h3F0, 8'h00, 3'b001, 3'b000, 8'h00};
    tbl[21] = '{3'b000, 3'b000, 10'h000, 8'h00, 3'b000, 3'b000, 8'h00};
    tbl[22] = '{3'b000, 3'b000, 10'h000, 8'h00, 3'b000, 3'b001, 8'h77};

    // reset with every requester asking
    rst_n = 1'b0;
    drive(3'b111, 3'b000, 10'h000, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 0, 32'(req_ready), 32'd0);
    chk("rst_en", 0, 32'(bram_en), 32'd0);
    chk("rst_rsp", 0, 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 0, 32'(rsp_rdata), 32'd0);
    rst_n = 1'b1;
    drive(3'b000, 3'b000, 10'h000, 8'h00);

    for (int r = 0; r < 23; r++) begin
      @(negedge clk);
      drive(tbl[r].v, tbl[r].we, tbl[r].base, tbl[r].d);
      #1;
      check_row(r, tbl[r]);
    end

    // idle: nothing moves, pointer holds
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(3'b000, 3'b000, 10'h000, 8'h00);
      #1;
      idle_check(100 + c);
    end
    @(negedge clk);
    drive(3'b111, 3'b000, 10'h000, 8'h00);
    #1;
    chk("post_idle_grant", 110, 32'(req_ready), F ? 32'h1 : 32'h2);
    @(negedge clk);
    drive(3'b000, 3'b000, 10'h000, 8'h00);
    #1;
    chk("post_idle_rsp1", 111, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("post_idle_rsp2", 112, 32'(rsp_valid), F ? 32'h1 : 32'h2);
    chk("post_idle_rdata", 112, 32'(rsp_rdata), F ? 32'h5A : 32'h5B);

    // reads to 0 then 2, reset while they are in flight
    @(negedge clk);
    drive(3'b001, 3'b000, 10'h010, 8'h00);
    #1;
    chk("pre_rst_g0", 200, 32'(req_ready), 32'h1);
    @(negedge clk);
    drive(3'b100, 3'b000, 10'h010, 8'h00);
    #1;
    chk("pre_rst_g2", 201, 32'(req_ready), 32'h4);
    @(negedge clk);
    drive(3'b111, 3'b000, 10'h010, 8'h00);
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      idle_check(202 + c);
      @(negedge clk);
      #1;
    end
    rst_n = 1'b1;
    drive(3'b111, 3'b111, 10'h3E0, 8'h00);
    #1;
    chk("first_grant", 205, 32'(req_ready), 32'h1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(3'b000, 3'b000, 10'h000, 8'h00);
      #1;
      chk("no_stale_rsp", 206 + c, 32'(rsp_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
